// File: rtl/pkt_rr_arb_pkg.sv
// rtl/pkt_rr_arb_pkg.sv - shared types and helpers for the packet round-robin arbiter
//
// Contents:
//   state_t   : arbiter FSM encoding (ST_IDLE = no packet open, ST_LOCKED = grant held)
//   clog2     : ceiling log2 for elaboration-time width math
//   id_width  : width of TDEST / ptr / gnt, never below 1
//   rr_next   : round-robin successor with explicit wrap at n-1 (n need not be a power of 2)
package pkt_rr_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pkt_rr_arb_if.sv
// rtl/pkt_rr_arb_if.sv - stream bundle between NUM_SRC sources, the arbiter and the sink
//
// Signals:
//   src_TDATA  [NUM_SRC*DATA_WIDTH] source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_TVALID [NUM_SRC]            per-source valid
//   src_TREADY [NUM_SRC]            per-source ready, at most one bit set
//   src_TLAST  [NUM_SRC]            per-source end of packet
//   res_TDATA  [DATA_WIDTH]         arbitrated payload
//   res_TVALID / res_TREADY         output handshake
//   res_TLAST                       output end of packet
//   res_TDEST  [ID_WIDTH]           index of the source that produced the flit
// Modports:
//   master : the environment side (drives sources, sinks the result)
//   slave  : the arbiter side
interface pkt_rr_arb_if
    import pkt_rr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_SRC    = 4
);
    localparam int ID_WIDTH = id_width(NUM_SRC);

    logic [NUM_SRC*DATA_WIDTH-1:0] src_TDATA;
    logic [NUM_SRC-1:0]            src_TVALID;
    logic [NUM_SRC-1:0]            src_TREADY;
    logic [NUM_SRC-1:0]            src_TLAST;
    logic [DATA_WIDTH-1:0]         res_TDATA;
    logic                          res_TVALID;
    logic                          res_TREADY;
    logic                          res_TLAST;
    logic [ID_WIDTH-1:0]           res_TDEST;

    modport master (
        output src_TDATA, src_TVALID, src_TLAST, res_TREADY,
        input  src_TREADY, res_TDATA, res_TVALID, res_TLAST, res_TDEST
    );

    modport slave (
        input  src_TDATA, src_TVALID, src_TLAST, res_TREADY,
        output src_TREADY, res_TDATA, res_TVALID, res_TLAST, res_TDEST
    );

endinterface

// File: rtl/pkt_rr_arb_skid.sv
// rtl/pkt_rr_arb_skid.sv - 2-entry skid buffer / register slice (module axis_skid)
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      upstream handshake; in_ready is purely registered
//   out_data/out_valid/out_ready   downstream handshake; out_* come straight from flops
// Full throughput with out_ready held high; one cycle from input handshake to out_valid.
module axis_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         main_v;
    logic         skid_v;
    logic         live_q;
    logic         in_fire;

    // live_q keeps ready low while reset is asserted and for the first edge after it
    assign in_ready  = live_q & ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (skid_v) begin
                // main is necessarily full here; drain the spare into it
                if (out_ready) begin
                    main_q <= skid_q;
                    skid_v <= 1'b0;
                end
            end else if (in_fire && main_v && !out_ready) begin
                skid_q <= in_data;
                skid_v <= 1'b1;
            end else if (in_fire) begin
                main_q <= in_data;
                main_v <= 1'b1;
            end else if (out_ready) begin
                main_v <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pkt_rr_arb.sv
// rtl/pkt_rr_arb.sv - packet-atomic NUM_SRC-way round-robin arbiter onto one stream
//
// Ports:
//   clk   single clock, all logic on posedge
//   rstn  asynchronous active-low reset
//   bus   pkt_rr_arb_if.slave: per-source src_* inputs, registered res_* output with TDEST tag
// A grant is held from the first flit to the TLAST flit; after each packet the search
// pointer moves one past the winner. Output passes through axis_skid.
module pkt_rr_arb
    import pkt_rr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_SRC    = 4
) (
    input logic         clk,
    input logic         rstn,
    pkt_rr_arb_if.slave bus
);
    localparam int ID_WIDTH = id_width(NUM_SRC);
    localparam int W        = DATA_WIDTH + 1 + ID_WIDTH;

    state_t                state_q;
    state_t                state_d;
    logic [ID_WIDTH-1:0]   ptr_q;
    logic [ID_WIDTH-1:0]   ptr_d;
    logic [ID_WIDTH-1:0]   gnt_r_q;
    logic [ID_WIDTH-1:0]   gnt_r_d;
    logic [ID_WIDTH-1:0]   gnt;
    logic                  gnt_found;
    logic [ID_WIDTH-1:0]   sel;
    logic                  sel_en;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  skid_in_valid;
    logic                  skid_in_ready;
    logic                  fire;
    logic [W-1:0]          skid_in_data;
    logic [W-1:0]          skid_out_data;

    // First valid source at or after ptr, wrapping; only meaningful while IDLE.
    always_comb begin : rr_search
        logic [ID_WIDTH-1:0] cand;
        gnt       = ptr_q;
        gnt_found = 1'b0;
        cand      = ptr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!gnt_found && bus.src_TVALID[cand]) begin
                gnt       = cand;
                gnt_found = 1'b1;
            end
            cand = ID_WIDTH'(rr_next(int'(cand), NUM_SRC));
        end
    end

    // While LOCKED the held grant is selected even when its valid is low, so the
    // owner keeps ready and nobody else can slip in during a bubble.
    assign sel    = (state_q == ST_LOCKED) ? gnt_r_q : gnt;
    assign sel_en = (state_q == ST_LOCKED) | gnt_found;

    always_comb begin : src_mux
        sel_data       = '0;
        sel_last       = 1'b0;
        sel_valid      = 1'b0;
        bus.src_TREADY = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == ID_WIDTH'(i)) begin
                sel_data          = bus.src_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last          = bus.src_TLAST[i];
                sel_valid         = bus.src_TVALID[i];
                bus.src_TREADY[i] = sel_en & skid_in_ready;
            end
        end
    end

    assign skid_in_valid = sel_en & sel_valid;
    assign skid_in_data  = {sel_data, sel_last, sel};
    assign fire          = skid_in_valid & skid_in_ready;

    always_comb begin : fsm_next
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_r_d = gnt_r_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    if (sel_last) begin
                        ptr_d = ID_WIDTH'(rr_next(int'(gnt), NUM_SRC));
                    end else begin
                        gnt_r_d = gnt;
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (fire && sel_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = ID_WIDTH'(rr_next(int'(gnt_r_q), NUM_SRC));
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_r_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_r_q <= gnt_r_d;
        end
    end

    axis_skid #(
        .W (W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rstn),
        .in_data   (skid_in_data),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out_data),
        .out_valid (bus.res_TVALID),
        .out_ready (bus.res_TREADY)
    );

    assign {bus.res_TDATA, bus.res_TLAST, bus.res_TDEST} = skid_out_data;

endmodule
